// File: rtl/dice_pkg.sv
// Shared types and constants for the dice front end and roller.
// Holds the button FSM states, bit positions and the seven-segment digit patterns.
package dice_pkg;

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_e;

   localparam int DIE_SIZE_W = 7;
   localparam int BTN_BIT    = 7;

   // Segment order is {g,f,e,d,c,b,a}, active high
   localparam logic [6:0] SEG7_0     = 7'h3F;
   localparam logic [6:0] SEG7_1     = 7'h06;
   localparam logic [6:0] SEG7_2     = 7'h5B;
   localparam logic [6:0] SEG7_3     = 7'h4F;
   localparam logic [6:0] SEG7_4     = 7'h66;
   localparam logic [6:0] SEG7_5     = 7'h6D;
   localparam logic [6:0] SEG7_6     = 7'h7D;
   localparam logic [6:0] SEG7_7     = 7'h07;
   localparam logic [6:0] SEG7_8     = 7'h7F;
   localparam logic [6:0] SEG7_9     = 7'h6F;
   localparam logic [6:0] SEG7_BLANK = 7'h00;

   function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
      case (digit)
         4'd0:    seg7_digit = SEG7_0;
         4'd1:    seg7_digit = SEG7_1;
         4'd2:    seg7_digit = SEG7_2;
         4'd3:    seg7_digit = SEG7_3;
         4'd4:    seg7_digit = SEG7_4;
         4'd5:    seg7_digit = SEG7_5;
         4'd6:    seg7_digit = SEG7_6;
         4'd7:    seg7_digit = SEG7_7;
         4'd8:    seg7_digit = SEG7_8;
         4'd9:    seg7_digit = SEG7_9;
         default: seg7_digit = SEG7_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/dice_sync2.sv
// Two-flop synchronizer of configurable width for asynchronous switch inputs.
// Both stages clear on synchronous reset.
module dice_sync2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dice_input_conditioner.sv
// Conditions the raw dice switches: synchronizes, debounces the roll button and qualifies die size.
// Optional feature macro DICE_AUTO_REPEAT_EN adds auto-repeat roll strobes while the button is held.
module dice_input_conditioner
   import dice_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4096,
   parameter int REPEAT_CYCLES   = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            ui_in,
   output logic [DIE_SIZE_W-1:0] die_size,
   output logic                  die_size_valid,
   output logic                  size_changed,
   output logic                  button_level,
   output logic                  press_pulse,
   output logic                  release_pulse,
   output logic                  roll_pulse
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [7:0]            sync_q;
   logic                  btn_s;
   logic [DIE_SIZE_W-1:0] size_s;

   btn_state_e            state, state_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic                  press_next, release_next, level_next;

   logic [DIE_SIZE_W-1:0] cand;
   logic [CNT_W-1:0]      scnt;

   dice_sync2 #(.WIDTH(8)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ui_in),
      .q     (sync_q)
   );

   assign btn_s  = sync_q[BTN_BIT];
   assign size_s = sync_q[DIE_SIZE_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         button_level  <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         button_level  <= level_next;
         press_pulse   <= press_next;
         release_pulse <= release_next;
      end
   end

   // Any sample disagreeing with the pending level restarts the debounce from the settled state
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_next = PRESS_WAIT;
               cnt_next   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s)              state_next = IDLE;
            else if (cnt == CNT_LAST) state_next = HELD;
            else                     cnt_next   = cnt + 1'b1;
         end
         HELD: begin
            if (!btn_s) begin
               state_next = RELEASE_WAIT;
               cnt_next   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s)               state_next = HELD;
            else if (cnt == CNT_LAST) state_next = IDLE;
            else                     cnt_next   = cnt + 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      press_next   = (state == PRESS_WAIT)   &&  btn_s && (cnt == CNT_LAST);
      release_next = (state == RELEASE_WAIT) && !btn_s && (cnt == CNT_LAST);
      level_next   = button_level;
      if (press_next)        level_next = 1'b1;
      else if (release_next) level_next = 1'b0;
   end

`ifdef DICE_AUTO_REPEAT_EN
   localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             repeat_fire;

   assign repeat_fire = (state == HELD) && btn_s && (rpt_cnt == RPT_LAST);

   // Repeat period restarts whenever the button leaves HELD, including bounces
   always_ff @(posedge clk) begin
      if (reset) begin
         rpt_cnt    <= '0;
         roll_pulse <= 1'b0;
      end else begin
         roll_pulse <= release_next | repeat_fire;
         if ((state == HELD) && btn_s) rpt_cnt <= repeat_fire ? '0 : rpt_cnt + 1'b1;
         else                          rpt_cnt <= '0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) roll_pulse <= 1'b0;
      else       roll_pulse <= release_next;
   end
`endif

   // Die size commits only after the candidate has been stable long enough and actually differs
   always_ff @(posedge clk) begin
      if (reset) begin
         cand         <= '0;
         scnt         <= '0;
         die_size     <= '0;
         size_changed <= 1'b0;
      end else begin
         size_changed <= 1'b0;
         if ((scnt == CNT_LAST) && (cand != die_size)) begin
            die_size     <= cand;
            size_changed <= 1'b1;
         end
         if (size_s != cand) begin
            cand <= size_s;
            scnt <= '0;
         end else if (scnt != CNT_LAST) begin
            scnt <= scnt + 1'b1;
         end
      end
   end

   assign die_size_valid = |die_size;

endmodule

// File: tb/tb_dice_input_conditioner.sv
// Self-checking bench for dice_input_conditioner: directed scenarios plus random switch activity,
// compared every cycle against a run-length reference model of the debounce rules.
module tb_dice_input_conditioner;

   localparam int D = 4;
   localparam int R = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] ui_in;
   logic [6:0] die_size;
   logic       die_size_valid, size_changed, button_level;
   logic       press_pulse, release_pulse, roll_pulse;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_s1, m_s2;
   logic       m_level, m_press, m_release, m_roll, m_sc;
   int         m_run, d_run, hold_dur;
   logic [6:0] d_prev, m_die;

   dice_input_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
      .clk            (clk),
      .reset          (reset),
      .ui_in          (ui_in),
      .die_size       (die_size),
      .die_size_valid (die_size_valid),
      .size_changed   (size_changed),
      .button_level   (button_level),
      .press_pulse    (press_pulse),
      .release_pulse  (release_pulse),
      .roll_pulse     (roll_pulse)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: a level is accepted once the synchronized input has disagreed with it for D+1 samples
   task automatic modelEdge();
      logic [7:0] s;
      if (reset) begin
         m_s1 = '0; m_s2 = '0;
         m_level = 1'b0; m_run = 0; hold_dur = 0;
         d_prev = '0; d_run = 1; m_die = '0;
         m_press = 1'b0; m_release = 1'b0; m_roll = 1'b0; m_sc = 1'b0;
      end else begin
         s = m_s2;
         m_s2 = m_s1;
         m_s1 = ui_in;
         m_press = 1'b0; m_release = 1'b0; m_roll = 1'b0; m_sc = 1'b0;

         if (d_run >= D && d_prev != m_die) begin
            m_die = d_prev;
            m_sc  = 1'b1;
         end
         if (s[6:0] == d_prev) begin
            if (d_run < 1000) d_run++;
         end else begin
            d_prev = s[6:0];
            d_run  = 1;
         end

`ifdef DICE_AUTO_REPEAT_EN
         if (m_level && m_run == 0 && s[7]) begin
            hold_dur++;
            if (hold_dur == R) begin
               m_roll   = 1'b1;
               hold_dur = 0;
            end
         end else begin
            hold_dur = 0;
         end
`endif

         if (s[7] != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
               m_level = s[7];
               m_run   = 0;
               if (s[7]) m_press   = 1'b1;
               else      m_release = 1'b1;
            end
         end else begin
            m_run = 0;
         end
         m_roll = m_roll | m_release;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] raw, input logic rst);
      ui_in = raw;
      reset = rst;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("die_size",       32'(die_size),       32'(m_die));
      checkOutput("die_size_valid", 32'(die_size_valid), 32'(m_die != 0));
      checkOutput("size_changed",   32'(size_changed),   32'(m_sc));
      checkOutput("button_level",   32'(button_level),   32'(m_level));
      checkOutput("press_pulse",    32'(press_pulse),    32'(m_press));
      checkOutput("release_pulse",  32'(release_pulse),  32'(m_release));
      checkOutput("roll_pulse",     32'(roll_pulse),     32'(m_roll));
   endtask

   initial begin
      int first, cnt_a, cnt_b, n;
      logic [6:0] sizes [4];
      logic [7:0] raw;
      sizes[0] = 7'd0; sizes[1] = 7'd6; sizes[2] = 7'd20; sizes[3] = 7'd12;

      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'h00, 1'b1);
      checkOutput("reset_outputs", {25'd0, die_size_valid, size_changed, button_level,
                  press_pulse, release_pulse, roll_pulse, |die_size}, 32'd0);
      checkOutput("reset_state", 32'(dut.state), 32'(dice_pkg::IDLE));

      first = 0; cnt_a = 0;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(8'h80, 1'b0);
         if (press_pulse) begin cnt_a++; if (first == 0) first = i; end
      end
      checkOutput("press_latency", first, D + 3);
      checkOutput("press_count", cnt_a, 1);
      checkOutput("held_level", 32'(button_level), 1);

      first = 0; cnt_b = 0;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(8'h00, 1'b0);
         if (release_pulse && first == 0) first = i;
         if (roll_pulse) cnt_b++;
      end
      checkOutput("release_latency", first, D + 3);
      checkOutput("release_roll_count", cnt_b, 1);

      cnt_a = 0;
      applyStimulus(8'h80, 1'b0);
      applyStimulus(8'h80, 1'b0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'h00, 1'b0);
         if (press_pulse) cnt_a++;
      end
      checkOutput("glitch_press", cnt_a, 0);
      checkOutput("glitch_state", 32'(dut.state), 32'(dice_pkg::IDLE));

      for (int i = 0; i < 12; i++) applyStimulus(8'h80, 1'b0);
      cnt_a = 0;
      applyStimulus(8'h00, 1'b0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'h80, 1'b0);
         if (release_pulse) cnt_a++;
      end
      checkOutput("bounce_release", cnt_a, 0);
      checkOutput("bounce_level", 32'(button_level), 1);
      for (int i = 0; i < 12; i++) applyStimulus(8'h00, 1'b0);

      cnt_a = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'h06, 1'b0);
         if (size_changed) cnt_a++;
      end
      checkOutput("size_strobe", cnt_a, 1);
      checkOutput("size_value", 32'(die_size), 6);
      checkOutput("size_valid", 32'(die_size_valid), 1);
      cnt_a = 0;
      applyStimulus(8'h14, 1'b0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'h06, 1'b0);
         if (size_changed) cnt_a++;
      end
      checkOutput("toggle_strobe", cnt_a, 0);
      checkOutput("toggle_value", 32'(die_size), 6);

      cnt_a = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'h86, 1'b0);
         if (press_pulse) cnt_a++;
      end
      applyStimulus(8'h86, 1'b1);
      checkOutput("midpress_press", cnt_a, 0);
      checkOutput("midpress_outputs", {24'd0, die_size, button_level}, 32'd0);
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(8'h86, 1'b0);
         if (press_pulse && first == 0) first = i;
      end
      checkOutput("restart_latency", first, D + 3);
      for (int i = 0; i < 15; i++) applyStimulus(8'h06, 1'b0);

      n = 0;
      do begin
         applyStimulus(8'h86, 1'b0);
         n++;
      end while (!press_pulse && n < 20);
      checkOutput("repeat_press_seen", 32'(press_pulse), 1);
      cnt_a = 0;
      for (int i = 0; i < 28; i++) begin
         applyStimulus(8'h86, 1'b0);
         if (roll_pulse) cnt_a++;
      end
      cnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(8'h06, 1'b0);
         if (roll_pulse) cnt_b++;
      end
`ifdef DICE_AUTO_REPEAT_EN
      checkOutput("repeat_rolls_held", cnt_a, 3);
`else
      checkOutput("repeat_rolls_held", cnt_a, 0);
`endif
      checkOutput("repeat_rolls_release", cnt_b, 1);

      for (int seg = 0; seg < 300; seg++) begin
         raw = {1'($urandom_range(0, 1)), sizes[$urandom_range(0, 3)]};
         n = $urandom_range(1, 9);
         for (int i = 0; i < n; i++)
            applyStimulus(raw, (i == 0) && ($urandom_range(0, 40) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
